zigzag_quantizer: RTL
=====================

ZIGZAG_QUANTIZER -- requirements
Module: zigzag_quantizer

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 11: signed width of quantized output.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nreset  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to process one 64-coefficient block.
REQ-005 SHALL have port coef_read_addr  output  6  row-major address into the 8x8 DCT result buffer.
REQ-006 SHALL have port coef_read_data  input  16  signed coefficient; valid one cycle after its address is presented (EBR read latency).
REQ-007 SHALL have port qtable_read_addr  output  6  row-major address into the reciprocal quant table.
REQ-008 SHALL have port qtable_read_data  input  16  unsigned Q0.16 reciprocal, round(65536/Q); one-cycle latency, same as coef_read_data.
REQ-009 SHALL have port out_valid  output  1  out_data/out_index/out_last are valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts this cycle; a transfer occurs when out_valid && out_ready.
REQ-011 SHALL have port out_data  output  OUT_WIDTH  signed quantized coefficient.
REQ-012 SHALL have port out_index  output  6  zigzag position k, 0..63.
REQ-013 SHALL have port out_last  output  1  high with the k=63 beat only.
REQ-014 SHALL have port busy  output  1  high from accepted start until the final transfer completes.
REQ-015 SHALL have port finished  output  1  high from the cycle after the k=63 transfer until the next accepted start.

Function
REQ-016 SHALL use states IDLE, RUN, DRAIN: IDLE->RUN on start; RUN->DRAIN after issuing read k=63; DRAIN->IDLE after the k=63 transfer.
REQ-017 SHALL ignore start while busy; start in IDLE SHALL be accepted even when finished is high, clearing finished.
REQ-018 SHALL present the same row-major address on coef_read_addr and qtable_read_addr, following the standard JPEG zigzag order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,... ending 61,54,47,55,62,63.
REQ-019 SHALL treat coefficient LSB as 1/16 (4 fractional bits) and compute q = (coef * recip + 2^19) >>> 20 (arithmetic shift).
REQ-020 SHALL use a signed intermediate of at least 33 bits, so that 32767*65535 + 2^19 does not overflow.
REQ-021 SHALL saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-022 SHALL pipeline as read-address -> data/multiply register -> output register.
REQ-023 First out_valid SHALL occur exactly 3 cycles after the accepted start cycle when out_ready is high.
REQ-024 SHALL sustain one transfer per cycle while out_ready stays high; a block completes in 66 cycles from start to the last transfer.
REQ-025 While out_valid && !out_ready, out_data, out_index and out_last SHALL hold stable.
REQ-026 Under any out_ready pattern, each k SHALL transfer exactly once, in ascending order, with no loss or duplication.
REQ-027 Reads SHALL be stalled or replayed so that in-flight data is buffered; internal buffering SHALL be at most 2 entries.
REQ-028 Read address outputs SHALL be 0 when no read is issued.
REQ-029 out_valid SHALL be low in IDLE.

Reset
REQ-030 nreset low SHALL asynchronously force IDLE and clear the pipeline.
REQ-031 During reset, out_valid, out_data, out_index, out_last, busy, finished, coef_read_addr and qtable_read_addr SHALL all be 0.
REQ-032 Reset asserted mid-block SHALL abort the block with no further out_valid.
REQ-033 After reset release, the block SHALL remain in IDLE until a new start.

Verification
REQ-034 Buffer all 1600 (value 100), recip 4096 (Q=16), out_ready=1 -> 64 beats of out_data=6; first beat 3 cycles after start; out_last at k=63; finished next cycle.
REQ-035 coef=-1600, recip 4096 -> out_data=-6; coef=32767, recip 65535 -> out_data=1023; coef=-32768, recip 65535 -> out_data=-1024.
REQ-036 Buffer[a]=a (LSB units), recip 65535 -> out_index k beats carry coef_read_addr matching zigzag table; out_index 0..63 strictly ascending.
REQ-037 Random out_ready (50%) -> outputs identical to REQ-034 sequence, held stable during stalls, exactly 64 transfers.
REQ-038 start pulsed again mid-block -> ignored, 64 transfers only; nreset low at k=20 -> all outputs 0 immediately, no further out_valid, new start processes a full block.

Source files
------------

// File: rtl/zigzag_quantizer_if.sv
// Output stream of the zigzag quantizer: one quantized coefficient per beat
// with a valid/ready handshake.
interface zigzag_quantizer_if #(
    parameter int unsigned OUT_WIDTH = 11
);
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic [5:0]                  out_index;
    logic                        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/zigzag_quantizer.sv
// Reads one 8x8 DCT block in zigzag order, multiplies each coefficient by its
// reciprocal quant step, rounds, saturates and streams it out with backpressure.
module zigzag_quantizer #(
    parameter int unsigned OUT_WIDTH = 11
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        start,
    output logic [5:0]  coef_read_addr,
    input  logic [15:0] coef_read_data,
    output logic [5:0]  qtable_read_addr,
    input  logic [15:0] qtable_read_data,
    output logic        busy,
    output logic        finished,
    zigzag_quantizer_if.master out_if
);

    localparam int unsigned PW         = 34;
    localparam int unsigned FRAC_SHIFT = 20;

    localparam logic signed [PW-1:0] ROUND_BIAS = PW'(2 ** 19);
    localparam logic signed [PW-1:0] Q_MAX      = PW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] Q_MIN      = PW'(-(2 ** (OUT_WIDTH - 1)));

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [1:0]                  state_q,    state_d;
    logic [5:0]                  iss_k_q,    iss_k_d;
    logic                        a_vld_q,    a_vld_d;
    logic [5:0]                  a_k_q,      a_k_d;
    logic [5:0]                  addr_q,     addr_d;
    logic                        d_vld_q,    d_vld_d;
    logic [5:0]                  d_k_q,      d_k_d;
    logic [6:0]                  acc_k_q,    acc_k_d;
    logic                        o_vld_q,    o_vld_d;
    logic signed [OUT_WIDTH-1:0] o_data_q,   o_data_d;
    logic [5:0]                  o_k_q,      o_k_d;
    logic                        o_last_q,   o_last_d;
    logic                        s_vld_q,    s_vld_d;
    logic signed [OUT_WIDTH-1:0] s_data_q,   s_data_d;
    logic [5:0]                  s_k_q,      s_k_d;
    logic                        s_last_q,   s_last_d;
    logic                        busy_q,     busy_d;
    logic                        finished_q, finished_d;

    logic signed [PW-1:0]        coef_ext_c;
    logic signed [PW-1:0]        recip_ext_c;
    logic signed [PW-1:0]        prod_c;
    logic signed [PW-1:0]        shifted_c;
    logic signed [OUT_WIDTH-1:0] q_c;
    logic                        pop_c;
    logic                        push_c;
    logic                        advance_c;

    // Q12.4 coefficient times Q0.16 reciprocal, rounded half-up, then clamped
    always_comb begin
        coef_ext_c  = {{(PW - 16){coef_read_data[15]}}, coef_read_data};
        recip_ext_c = {{(PW - 16){1'b0}}, qtable_read_data};
        prod_c      = coef_ext_c * recip_ext_c + ROUND_BIAS;
        shifted_c   = prod_c >>> FRAC_SHIFT;
        if (shifted_c > Q_MAX) begin
            q_c = Q_MAX[OUT_WIDTH-1:0];
        end else if (shifted_c < Q_MIN) begin
            q_c = Q_MIN[OUT_WIDTH-1:0];
        end else begin
            q_c = shifted_c[OUT_WIDTH-1:0];
        end
    end

    // Output register plus one skid entry; the read address only advances when
    // the word it fetches is certain to find room, otherwise it is re-read and
    // stale repeats are dropped by matching against the next expected k.
    always_comb begin
        state_d    = state_q;
        iss_k_d    = iss_k_q;
        a_vld_d    = a_vld_q;
        a_k_d      = a_k_q;
        addr_d     = addr_q;
        d_vld_d    = a_vld_q;
        d_k_d      = a_k_q;
        acc_k_d    = acc_k_q;
        o_vld_d    = o_vld_q;
        o_data_d   = o_data_q;
        o_k_d      = o_k_q;
        o_last_d   = o_last_q;
        s_vld_d    = s_vld_q;
        s_data_d   = s_data_q;
        s_k_d      = s_k_q;
        s_last_d   = s_last_q;
        busy_d     = busy_q;
        finished_d = finished_q;

        pop_c  = o_vld_q && out_if.out_ready;
        push_c = d_vld_q && ({1'b0, d_k_q} == acc_k_q) && (!(o_vld_q && s_vld_q) || pop_c);

        if (pop_c) begin
            if (s_vld_q) begin
                o_data_d = s_data_q;
                o_k_d    = s_k_q;
                o_last_d = s_last_q;
            end else begin
                o_vld_d = 1'b0;
            end
            s_vld_d = 1'b0;
        end

        if (push_c) begin
            if (!o_vld_d) begin
                o_vld_d  = 1'b1;
                o_data_d = q_c;
                o_k_d    = d_k_q;
                o_last_d = (d_k_q == 6'd63);
            end else begin
                s_vld_d  = 1'b1;
                s_data_d = q_c;
                s_k_d    = d_k_q;
                s_last_d = (d_k_q == 6'd63);
            end
            acc_k_d = acc_k_q + 7'd1;
        end

        advance_c = !(o_vld_d && s_vld_d);
        if (advance_c) begin
            a_vld_d = 1'b0;
            addr_d  = 6'd0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    a_vld_d    = 1'b1;
                    a_k_d      = 6'd0;
                    addr_d     = ZIGZAG[0];
                    iss_k_d    = 6'd1;
                    acc_k_d    = 7'd0;
                    busy_d     = 1'b1;
                    finished_d = 1'b0;
                end
            end
            RUN: begin
                if (advance_c) begin
                    a_vld_d = 1'b1;
                    a_k_d   = iss_k_q;
                    addr_d  = ZIGZAG[iss_k_q];
                    iss_k_d = iss_k_q + 6'd1;
                    if (iss_k_q == 6'd63) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_c && o_last_q) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    finished_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            iss_k_q    <= '0;
            a_vld_q    <= 1'b0;
            a_k_q      <= '0;
            addr_q     <= '0;
            d_vld_q    <= 1'b0;
            d_k_q      <= '0;
            acc_k_q    <= '0;
            o_vld_q    <= 1'b0;
            o_data_q   <= '0;
            o_k_q      <= '0;
            o_last_q   <= 1'b0;
            s_vld_q    <= 1'b0;
            s_data_q   <= '0;
            s_k_q      <= '0;
            s_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            iss_k_q    <= iss_k_d;
            a_vld_q    <= a_vld_d;
            a_k_q      <= a_k_d;
            addr_q     <= addr_d;
            d_vld_q    <= d_vld_d;
            d_k_q      <= d_k_d;
            acc_k_q    <= acc_k_d;
            o_vld_q    <= o_vld_d;
            o_data_q   <= o_data_d;
            o_k_q      <= o_k_d;
            o_last_q   <= o_last_d;
            s_vld_q    <= s_vld_d;
            s_data_q   <= s_data_d;
            s_k_q      <= s_k_d;
            s_last_q   <= s_last_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

    assign coef_read_addr   = addr_q;
    assign qtable_read_addr = addr_q;
    assign busy             = busy_q;
    assign finished         = finished_q;
    assign out_if.out_valid = o_vld_q;
    assign out_if.out_data  = o_data_q;
    assign out_if.out_index = o_k_q;
    assign out_if.out_last  = o_last_q;

endmodule
